// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract sequencer.
//   state_e        : sequencer FSM states
//   DEF_WIDTH      : default operand/sum width
//   DEF_EVAL_CYCLES: default number of evaluate cycles before capture
//   eval_cnt_width : width of the evaluate down-counter for a given cycle count
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_EVAL_CYCLES = 2;

  // Counter must be able to hold EVAL_CYCLES-1; sized on EVAL_CYCLES+1 so it is never zero-width.
  function automatic int unsigned eval_cnt_width(input int unsigned eval_cycles);
    return $clog2(eval_cycles + 1);
  endfunction

endpackage

// File: rtl/addsub_eval_timer.sv
// Loadable down-counter timing the domino evaluate window.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : load count with load_val (has priority over dec)
//   dec        : decrement count, saturating at zero
//   load_val   : value loaded on load
//   zero_c     : combinational flag, count == 0
module addsub_eval_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] count_q;

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/addsub_seq.sv
// Sequencer and register stage around the domino add/subtract datapath.
// Accepts A/B/sub over a valid/ready handshake, holds them on the datapath,
// runs one precharge cycle then EVAL_CYCLES evaluate cycles, captures the
// datapath sum/carry-out, and offers the result over a second handshake.
// Optional feature: define ADDSUB_OVF_EN to generate the signed-overflow
// flag; otherwise ovf is tied to 0.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake
//   a, b, sub            : operands, sub=1 selects a-b
//   dp_a, dp_b, dp_sub   : registered operands driven to the datapath
//   dp_eval              : registered domino evaluate enable (0 = precharge)
//   dp_sum, dp_cout      : datapath result
//   out_valid / out_ready: result handshake
//   sum, cout, ovf       : captured result (cout=1 on subtract means no borrow)
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned EVAL_CYCLES = DEF_EVAL_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic             dp_sub,
  output logic             dp_eval,
  input  logic [WIDTH-1:0] dp_sum,
  input  logic             dp_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = eval_cnt_width(EVAL_CYCLES);

  // Parameter sanity
  generate
    if (EVAL_CYCLES < 1) begin : g_bad_eval_cycles
      $error("addsub_seq: EVAL_CYCLES must be at least 1");
    end
    if (WIDTH < 2) begin : g_bad_width
      $error("addsub_seq: WIDTH must be at least 2");
    end
  endgenerate

  state_e state_q;
  state_e state_d;
  logic   accept_c;
  logic   capture_c;
  logic   tmr_load_c;
  logic   tmr_dec_c;
  logic   tmr_zero_c;

  // Evaluate window timer
  addsub_eval_timer #(
    .CNT_W (CNT_W)
  ) u_eval_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_c),
    .dec      (tmr_dec_c),
    .load_val (CNT_W'(EVAL_CYCLES - 1)),
    .zero_c   (tmr_zero_c)
  );

  // FSM state register plus registered handshake/evaluate outputs (decoded from next state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dp_eval   <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      dp_eval   <= (state_d == EVAL);
    end
  end

  // Next-state and timer control
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    capture_c  = 1'b0;
    tmr_load_c = 1'b0;
    tmr_dec_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = PRE;
        end
      end
      PRE: begin
        tmr_load_c = 1'b1;
        state_d    = EVAL;
      end
      EVAL: begin
        // Last evaluate cycle is the one that finds the counter already at zero.
        if (tmr_zero_c) begin
          capture_c = 1'b1;
          state_d   = DONE;
        end else begin
          tmr_dec_c = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand registers, updated only on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_a   <= '0;
      dp_b   <= '0;
      dp_sub <= 1'b0;
    end else if (accept_c) begin
      dp_a   <= a;
      dp_b   <= b;
      dp_sub <= sub;
    end
  end

  // Result registers, sampled on the final evaluate edge only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (capture_c) begin
      sum  <= dp_sum;
      cout <= dp_cout;
    end
  end

`ifdef ADDSUB_OVF_EN
  logic bx_msb_c;
  logic ovf_c;

  // Overflow when the effective operands agree in sign but the sum does not
  assign bx_msb_c = dp_b[WIDTH-1] ^ dp_sub;
  assign ovf_c    = (dp_a[WIDTH-1] == bx_msb_c) && (dp_sum[WIDTH-1] != dp_a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (capture_c) begin
      ovf <= ovf_c;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq with a behavioural domino datapath model.
module tb_addsub_seq;

  localparam int unsigned W  = 8;
  localparam int unsigned EC = 2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic [W-1:0] dp_a;
  logic [W-1:0] dp_b;
  logic         dp_sub;
  logic         dp_eval;
  logic [W-1:0] dp_sum;
  logic         dp_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  addsub_seq #(
    .WIDTH       (W),
    .EVAL_CYCLES (EC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_sub    (dp_sub),
    .dp_eval   (dp_eval),
    .dp_sum    (dp_sum),
    .dp_cout   (dp_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: garbage while precharged, valid result one cycle after evaluate rises
  always @(posedge clk) begin
    logic [W:0] r;
    if (dp_eval) begin
      r = {1'b0, dp_a} + {1'b0, dp_b ^ {W{dp_sub}}} + (W+1)'(dp_sub);
      dp_sum  <= r[W-1:0];
      dp_cout <= r[W];
    end else begin
      dp_sum  <= W'($urandom);
      dp_cout <= 1'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned result with carry/no-borrow, and signed overflow
  function automatic logic [W:0] ref_res(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                         input logic rs);
    int unsigned ua = ra;
    int unsigned ub = rb;
    if (!rs) return (W+1)'(ua + ub);
    return {(ua >= ub) ? 1'b1 : 1'b0, W'(ua - ub)};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                   input logic rs);
`ifdef ADDSUB_OVF_EN
    int sa = int'($signed(ra));
    int sb = int'($signed(rb));
    int r  = rs ? (sa - sb) : (sa + sb);
    return (r > 127) || (r < -128);
`else
    return 1'b0;
`endif
  endfunction

  // One full transaction with cycle-exact checks; busy_junk drives in_valid with junk while busy
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                       input logic busy_junk, input int hold);
    logic [W:0] er;
    er = ref_res(oa, ob, os);
    chk("ready_before_accept", 32'(in_ready), 1);
    in_valid = 1'b1;
    a = oa;
    b = ob;
    sub = os;
    tick();
    in_valid = busy_junk;
    a = ~oa;
    b = ~ob;
    sub = ~os;
    for (int k = 1; k <= int'(EC) + 1; k++) begin
      chk("dp_eval_window", 32'(dp_eval), (k >= 2) ? 1 : 0);
      chk("busy_out_valid", 32'(out_valid), 0);
      chk("busy_in_ready", 32'(in_ready), 0);
      chk("dp_a_held", 32'(dp_a), 32'(oa));
      tick();
    end
    chk("out_valid_rise", 32'(out_valid), 1);
    chk("done_dp_eval", 32'(dp_eval), 0);
    chk("sum", 32'(sum), 32'(er[W-1:0]));
    chk("cout", 32'(cout), 32'(er[W]));
    chk("ovf", 32'(ovf), 32'(ref_ovf(oa, ob, os)));
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_sum", 32'(sum), 32'(er[W-1:0]));
      chk("hold_out_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_dp_a", 32'(dp_a), 32'(oa));
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("ready_after_consume", 32'(in_ready), 1);
    chk("valid_after_consume", 32'(out_valid), 0);
    chk("dp_a_after_done", 32'(dp_a), 32'(oa));
    chk("dp_sub_after_done", 32'(dp_sub), 32'(os));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_dp_eval", 32'(dp_eval), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_dp_a", 32'(dp_a), 0);

    // Directed vectors
    do_op(8'h35, 8'h4A, 1'b0, 1'b0, 0);
    do_op(8'h10, 8'h20, 1'b1, 1'b0, 0);
    do_op(8'h20, 8'h10, 1'b1, 1'b0, 0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h80, 8'h01, 1'b1, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b1, 0);
    do_op(8'h00, 8'h00, 1'b1, 1'b0, 0);

    // Backpressure with new operands presented while the result waits
    do_op(8'hC3, 8'h5A, 1'b0, 1'b1, 5);

    // Randomized operations
    for (int n = 0; n < 24; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)));
    end

    // Reset asserted mid-evaluate, between clock edges
    in_valid = 1'b1;
    a = 8'h11;
    b = 8'h22;
    sub = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("abort_eval_high", 32'(dp_eval), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_dp_eval_async", 32'(dp_eval), 0);
    chk("abort_in_ready_async", 32'(in_ready), 1);
    chk("abort_out_valid_async", 32'(out_valid), 0);
    chk("abort_dp_a_async", 32'(dp_a), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("abort_no_out_valid", 32'(out_valid), 0);
      chk("abort_idle_ready", 32'(in_ready), 1);
    end

    // Normal operation after the abort
    do_op(8'h7F, 8'h80, 1'b1, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Sequencing and register stage wrapped around the domino add/subtract datapath (XOR3 sum slices plus carry chain). Accepts an operand pair and a Sub flag over a valid/ready handshake and holds them stable on the datapath. Drives the domino precharge/evaluate enable, captures the evaluated sum and carry-out, and presents the result over a second valid/ready handshake. The block sits directly upstream of the XOR3 sum slices and also consumes their outputs.

## Interface
- WIDTH, 8: operand/sum width in bits (≥2)
- EVAL_CYCLES, 2: Clk cycles Dp_Eval is held high before capture (≥1; 0 is an elaboration error)

- Clk  input  1  single clock, rising edge
- Rst_  input  1  asynchronous, active-low reset
- In_Valid  input  1  operand pair valid
- In_Ready  output  1  block can accept operands
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Sub  input  1  1 = A−B, 0 = A+B
- Dp_A  output  WIDTH  registered A to datapath
- Dp_B  output  WIDTH  registered B to datapath (datapath inverts internally)
- Dp_Sub  output  1  registered Sub to datapath and carry-in
- Dp_Eval  output  1  registered domino evaluate enable (0 = precharge)
- Dp_Sum  input  WIDTH  datapath sum
- Dp_Cout  input  1  datapath carry-out
- Out_Valid  output  1  result valid
- Out_Ready  input  1  consumer accepts result
- Sum  output  WIDTH  captured sum
- Cout  output  1  captured carry-out (for Sub=1: 1 = no borrow)
- Ovf  output  1  signed overflow (only with ADDSUB_OVF_EN, else tied 0)

## Operation
- FSM states: IDLE, PRE, EVAL, DONE. Reset state: IDLE.
- IDLE: In_Ready=1. On In_Valid && In_Ready, register A/B/Sub into Dp_A/Dp_B/Dp_Sub and go to PRE.
- PRE: Dp_Eval=0 for exactly one cycle. Load the eval counter with EVAL_CYCLES−1 and go to EVAL.
- EVAL: Dp_Eval=1. Decrement the counter each cycle. When the counter reaches 0, capture Dp_Sum and Dp_Cout into Sum and Cout on that edge, compute Ovf, then go to DONE with Dp_Eval=0.
- DONE: Out_Valid=1. Sum, Cout and Ovf are held stable until Out_Valid && Out_Ready, after which the FSM returns to IDLE.
- In_Ready=0 in PRE, EVAL and DONE. In_Valid is ignored in those states and does not cause a queued accept.
- Dp_A, Dp_B and Dp_Sub change only on an accept. They hold their value after DONE until the next accept.
- Dp_Eval is a flop output with no combinational path from any input, so it is glitch-free.
- Reset values: In_Ready=1; Out_Valid=0; Dp_Eval=0; Dp_A, Dp_B, Sum=0; Dp_Sub, Cout, Ovf=0.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronously). Dp_Eval drops without waiting for Clk. The in-flight operation is discarded and no Out_Valid is produced.

## Timing
- Accept at edge t gives PRE during cycle t+1 and EVAL during cycles t+2 … t+1+EVAL_CYCLES.
- Out_Valid rises at t+2+EVAL_CYCLES (t+4 with default parameters).
- Result consumed at edge u gives In_Ready=1 in cycle u+1.
- Minimum interval between accepts is EVAL_CYCLES+3 cycles.
- Dp_Sum and Dp_Cout must settle within EVAL_CYCLES cycles of Dp_Eval rising. The block samples them only on the final EVAL edge.

## Configuration
- ADDSUB_OVF_EN defined:
  - Ovf is registered with Sum.
  - Ovf = (A[W−1] == Bx[W−1]) && (Sum[W−1] != A[W−1]), where Bx = B ^ {WIDTH{Sub}} and A is Dp_A.
- ADDSUB_OVF_EN undefined:
  - No overflow logic is generated.
  - Ovf is constant 0.

## Structure
- Package addsub_pkg holds:
  - the FSM state enum (IDLE, PRE, EVAL, DONE)
  - the default WIDTH and EVAL_CYCLES constants
  - the eval counter width function, $clog2(EVAL_CYCLES+1)
- One sub-module, addsub_eval_timer: a loadable down-counter with load, dec and zero flag, driven by the FSM.
- The FSM, operand registers and result registers live in addsub_seq.

## Test plan
All scenarios use WIDTH=8, EVAL_CYCLES=2, and a behavioural datapath model that drives Dp_Sum/Dp_Cout one cycle after Dp_Eval rises.
- Reset held for 3 cycles, then released → In_Ready=1; Out_Valid, Dp_Eval, Sum, Cout and Ovf all 0.
- A=0x35, B=0x4A, Sub=0 accepted at t → Dp_Eval=1 during t+2 and t+3 only; Out_Valid=1 at t+4; Sum=0x7F, Cout=0.
- A=0x10, B=0x20, Sub=1 → Sum=0xF0, Cout=0 (borrow). Then A=0x20, B=0x10, Sub=1 → Sum=0x10, Cout=1.
- A=0x7F, B=0x01, Sub=0 → Sum=0x80, Ovf=1 with ADDSUB_OVF_EN and Ovf=0 without it. A=0x80, B=0x01, Sub=1 → Sum=0x7F, Ovf=1 with the macro.
- Out_Ready held low for 5 cycles in DONE with In_Valid=1 and new operands applied → Sum stable, In_Ready=0, Dp_A unchanged. Out_Ready=1 → In_Ready=1 the next cycle.
- Rst_ pulled low mid-EVAL, between edges → Dp_Eval=0 before the next Clk edge. After release: IDLE, and no Out_Valid for the aborted operands.
